// File: rtl/usr_seq_ctrl_if.sv
// Command handshake between a requester and the shift-register sequencer.
interface usr_seq_ctrl_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_fill;

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill,
        output cmd_ready
    );
endinterface

// File: rtl/usr_seq_ctrl.sv
// Sequencer that turns load/shift/rotate commands into cycle-by-cycle
// mode, load, data and serial-in drives for a universal shift register.
module usr_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    usr_seq_ctrl_if.slave    cmd,
    output logic [1:0]       usr_s,
    output logic             usr_ld,
    output logic [WIDTH-1:0] usr_din,
    output logic             usr_sin,
    input  logic [WIDTH-1:0] usr_q,
    output logic             busy,
    output logic             done
);
    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SHL    = 2'b10;
    localparam logic [1:0] OP_ROTR   = 2'b11;
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] remaining;
    logic             ready;
    logic             sin_r;
    logic             rot_active;
    logic             unused_q;

    // Only usr_q[0] is fed back (rotate); the upper bits are observed but not needed.
    assign unused_q      = ^usr_q[WIDTH-1:1];
    assign cmd.cmd_ready = ready;
    assign rot_active    = (state == SHIFT) && (op_q == OP_ROTR);
    assign usr_sin       = rot_active ? usr_q[0] : sin_r;

    // State, latched command fields and registered output drives.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            op_q      <= OP_LOAD;
            remaining <= '0;
            ready     <= 1'b1;
            usr_s     <= MODE_HOLD;
            usr_ld    <= 1'b0;
            usr_din   <= '0;
            sin_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd.cmd_valid && ready) begin
                        op_q  <= cmd.cmd_op;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        if (cmd.cmd_op == OP_LOAD) begin
                            state   <= LOAD;
                            usr_s   <= MODE_LOAD;
                            usr_ld  <= 1'b1;
                            usr_din <= cmd.cmd_data;
                        end else if (cmd.cmd_cnt == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= SHIFT;
                            remaining <= cmd.cmd_cnt;
                            usr_s     <= (cmd.cmd_op == OP_SHL) ? MODE_SHL : MODE_SHR;
                            sin_r     <= (cmd.cmd_op == OP_ROTR) ? 1'b0 : cmd.cmd_fill;
                        end
                    end
                end
                LOAD: begin
                    state   <= DONE;
                    usr_s   <= MODE_HOLD;
                    usr_ld  <= 1'b0;
                    usr_din <= '0;
                    done    <= 1'b1;
                end
                SHIFT: begin
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state <= DONE;
                        usr_s <= MODE_HOLD;
                        sin_r <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Directed bench for usr_seq_ctrl driving a behavioural 4-bit universal shift register.
module tb_usr_seq_ctrl;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       usr_s;
    logic             usr_ld;
    logic [WIDTH-1:0] usr_din;
    logic             usr_sin;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    usr_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_if ();

    usr_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cmd_if),
        .usr_s   (usr_s),
        .usr_ld  (usr_ld),
        .usr_din (usr_din),
        .usr_sin (usr_sin),
        .usr_q   (q),
        .busy    (busy),
        .done    (done)
    );

    // Universal shift register the controller drives; it has no reset of its own.
    initial q = 4'b0110;
    always @(posedge clk) begin
        case (usr_s)
            2'b01:   q <= {usr_sin, q[3:1]};
            2'b10:   q <= {q[2:0], usr_sin};
            2'b11:   q <= usr_din;
            default: ;
        endcase
    end

    typedef struct packed {
        logic [3:0] q;
        int         at;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [3:0] mdl_q;
    int         errors   = 0;
    int         checks   = 0;
    int         cyc      = 0;
    int         acc_cnt  = 0;
    int         done_cnt = 0;
    bit         mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] apply(input logic [3:0] q0, input logic [1:0] op,
                                         input int cnt, input logic [3:0] d, input logic f);
        logic [3:0] r;
        r = q0;
        if (op == 2'b00) return d;
        for (int i = 0; i < cnt; i++) begin
            case (op)
                2'b01:   r = {f, r[3:1]};
                2'b10:   r = {r[2:0], f};
                default: r = {r[0], r[3:1]};
            endcase
        end
        return r;
    endfunction

    // Present a command, hold it until accepted, then queue the expected outcome.
    task automatic send(input logic [1:0] op, input int cnt, input logic [3:0] d, input logic f);
        int waited;
        int lat;
        waited = 0;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_cnt   = 3'(cnt);
        cmd_if.cmd_data  = d;
        cmd_if.cmd_fill  = f;
        cmd_if.cmd_valid = 1'b1;
        while (cmd_if.cmd_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_wait", 32'(waited < 40), 32'd1);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        lat   = (op == 2'b00) ? 2 : ((cnt == 0) ? 1 : cnt + 1);
        mdl_q = apply(mdl_q, op, cnt, d, f);
        sb.push_back('{q: mdl_q, at: cyc + lat - 1});
        acc_cnt++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 32'(n < 60), 32'd1);
    endtask

    // Output monitor: invariants every cycle, scoreboard pop on done.
    always @(negedge clk) begin
        if (mon_en && rst === 1'b1) begin
            chk("ld_decode", 32'(usr_ld), 32'(usr_s == 2'b11));
            chk("ready_vs_busy", 32'(cmd_if.cmd_ready), 32'(!busy));
            if (!usr_ld) chk("din_zero", 32'(usr_din), 32'd0);
            if (usr_s == 2'b00 || usr_s == 2'b11) chk("sin_zero", 32'(usr_sin), 32'd0);
            if (done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_q", 32'(q), 32'(e.q));
                    chk("done_cycle", 32'(cyc), 32'(e.at));
                end
            end
        end
    end

    initial begin
        rst              = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'b10;
        cmd_if.cmd_cnt   = 3'd1;
        cmd_if.cmd_data  = 4'b0000;
        cmd_if.cmd_fill  = 1'b1;
        mdl_q            = 4'b0110;

        // Reset held with a command pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_usr_s", 32'(usr_s), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ld", 32'(usr_ld), 32'd0);
        chk("rst_din", 32'(usr_din), 32'd0);
        chk("rst_sin", 32'(usr_sin), 32'd0);
        cmd_if.cmd_valid = 1'b0;
        rst              = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        chk("rst_q_kept", 32'(q), 32'b0110);
        mon_en = 1'b1;

        // Parallel load.
        send(2'b00, 0, 4'b1011, 1'b0);
        @(negedge clk);
        chk("load_s", 32'(usr_s), 32'd3);
        chk("load_ld", 32'(usr_ld), 32'd1);
        chk("load_din", 32'(usr_din), 32'b1011);
        chk("load_busy", 32'(busy), 32'd1);
        wait_idle();
        chk("load_q", 32'(q), 32'b1011);
        chk("load_ready", 32'(cmd_if.cmd_ready), 32'd1);

        // Shift right then left.
        @(negedge clk);
        send(2'b01, 2, 4'b0000, 1'b0);
        @(negedge clk);
        chk("shr_s", 32'(usr_s), 32'd1);
        wait_idle();
        chk("shr_q", 32'(q), 32'b0010);
        @(negedge clk);
        send(2'b10, 3, 4'b0000, 1'b1);
        @(negedge clk);
        chk("shl_s", 32'(usr_s), 32'd2);
        chk("shl_sin", 32'(usr_sin), 32'd1);
        wait_idle();
        chk("shl_q", 32'(q), 32'b0111);

        // Rotate, rotate with wrap, flushing shift.
        @(negedge clk);
        send(2'b00, 0, 4'b1011, 1'b0);
        wait_idle();
        @(negedge clk);
        send(2'b11, 1, 4'b0000, 1'b0);
        wait_idle();
        chk("rotr1_q", 32'(q), 32'b1101);
        @(negedge clk);
        send(2'b11, 5, 4'b0000, 1'b1);
        wait_idle();
        chk("rotr5_q", 32'(q), 32'b1110);
        @(negedge clk);
        send(2'b01, 7, 4'b0000, 1'b1);
        wait_idle();
        chk("flush_q", 32'(q), 32'b1111);

        // Zero count completes the cycle after accept without touching q.
        @(negedge clk);
        send(2'b10, 0, 4'b0000, 1'b0);
        @(negedge clk);
        chk("cnt0_done", 32'(done), 32'd1);
        chk("cnt0_q", 32'(q), 32'b1111);
        wait_idle();

        // Second command held valid while the first is busy.
        @(negedge clk);
        send(2'b01, 3, 4'b0000, 1'b0);
        send(2'b10, 1, 4'b0000, 1'b1);
        wait_idle();
        chk("held_q", 32'(q), 32'b0011);
        chk("done_per_accept", 32'(done_cnt), 32'(acc_cnt));

        // Reset in the middle of a shift aborts without done.
        @(negedge clk);
        send(2'b00, 0, 4'b1111, 1'b0);
        wait_idle();
        @(negedge clk);
        send(2'b01, 6, 4'b0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_q1", 32'(q), 32'b0111);
        rst = 1'b0;
        @(negedge clk);
        sb.delete();
        acc_cnt--;
        mdl_q = 4'b0011;
        chk("abort_s", 32'(usr_s), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ready", 32'(cmd_if.cmd_ready), 32'd1);
        chk("abort_q2", 32'(q), 32'b0011);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_hold_q", 32'(q), 32'b0011);
            chk("abort_hold_busy", 32'(busy), 32'd0);
        end
        chk("final_done_count", 32'(done_cnt), 32'(acc_cnt));
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
